// File: rtl/rm_stream_framer.sv
// rm_stream_framer: cuts a raw accelerator stream into fixed-length AXI-Stream
// frames. It inserts TLAST and masks TKEEP on the final beat, and flags upstream
// TLAST that arrives early. Beats leave through a 2-entry skid buffer, so
// m_axis_TREADY never reaches s_axis_tready combinationally.
module rm_stream_framer #(
  parameter int DATA_W = 128,
  parameter int KEEP_W = 16,
  parameter int LEN_W  = 24,
  parameter int DEST_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_enable,
  input  logic [LEN_W-1:0]  cfg_frame_bytes,
  input  logic [DEST_W-1:0] cfg_tdest,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic [KEEP_W-1:0] s_axis_tkeep,
  input  logic              s_axis_tlast,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  output logic [DATA_W-1:0] m_axis_TDATA,
  output logic [KEEP_W-1:0] m_axis_TKEEP,
  output logic              m_axis_TLAST,
  output logic [DEST_W-1:0] m_axis_TUSER,
  output logic [DEST_W-1:0] m_axis_TID,
  output logic [DEST_W-1:0] m_axis_TDEST,
  output logic              m_axis_TVALID,
  input  logic              m_axis_TREADY,
  output logic [31:0]       frame_count,
  output logic              early_last_err,
  output logic              busy
);
  localparam int KB = $clog2(KEEP_W);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [KEEP_W-1:0] keep;
    logic              last;
    logic [DEST_W-1:0] dest;
  } beat_t;

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t            state, state_n;
  logic [LEN_W-1:0]  rem, rem_n;
  logic [KEEP_W-1:0] mask_q, mask_n;
  logic [DEST_W-1:0] tdest_q, tdest_n;
  logic              pass_q, pass_n;
  logic              err_set;
  beat_t             nxt;
  beat_t             ent0, ent1;
  logic [1:0]        cnt, cnt_n;
  logic              accept, pop;

  // Frame geometry derived from the live config; only used at a frame start.
  logic [LEN_W:0]    bytes_rnd;
  logic [LEN_W-1:0]  beats;
  logic [KB-1:0]     tail;
  logic [KEEP_W-1:0] start_mask;

  assign accept    = s_axis_tvalid && s_axis_tready;
  assign pop       = m_axis_TVALID && m_axis_TREADY;
  assign bytes_rnd = {1'b0, cfg_frame_bytes} + (LEN_W+1)'(KEEP_W - 1);
  assign beats     = LEN_W'(bytes_rnd >> KB);
  assign tail      = cfg_frame_bytes[KB-1:0];
  assign cnt_n     = cnt + {1'b0, accept} - {1'b0, pop};

  // Byte mask for the last beat: all ones when the length is a whole number of beats.
  always_comb begin
    start_mask = '0;
    for (int i = 0; i < KEEP_W; i++)
      start_mask[i] = (tail == '0) || (i < int'(tail));
  end

  // Framing decision for the beat being accepted this cycle.
  always_comb begin
    state_n   = state;
    rem_n     = rem;
    mask_n    = mask_q;
    tdest_n   = tdest_q;
    pass_n    = pass_q;
    err_set   = 1'b0;
    nxt.data  = s_axis_tdata;
    nxt.keep  = s_axis_tkeep;
    nxt.last  = 1'b0;
    nxt.dest  = tdest_q;
    if (accept) begin
      case (state)
        IDLE: begin
          tdest_n  = cfg_tdest;
          nxt.dest = cfg_tdest;
          mask_n   = start_mask;
          pass_n   = (cfg_frame_bytes == '0);
          if (cfg_frame_bytes == '0) begin
            nxt.last = s_axis_tlast;
            if (!s_axis_tlast) state_n = ACTIVE;
          end else if (beats == LEN_W'(1)) begin
            nxt.last = 1'b1;
            nxt.keep = s_axis_tkeep & start_mask;
          end else if (s_axis_tlast) begin
            nxt.last = 1'b1;
            err_set  = 1'b1;
          end else begin
            state_n = ACTIVE;
            rem_n   = beats - LEN_W'(1);
          end
        end
        ACTIVE: begin
          if (pass_q) begin
            nxt.last = s_axis_tlast;
            if (s_axis_tlast) state_n = IDLE;
          end else if (rem == LEN_W'(1)) begin
            nxt.last = 1'b1;
            nxt.keep = s_axis_tkeep & mask_q;
            state_n  = IDLE;
          end else if (s_axis_tlast) begin
            nxt.last = 1'b1;
            err_set  = 1'b1;
            state_n  = IDLE;
          end else begin
            rem_n = rem - LEN_W'(1);
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // Framer state, per-frame latches and sticky error.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      rem            <= '0;
      mask_q         <= '0;
      tdest_q        <= '0;
      pass_q         <= 1'b0;
      early_last_err <= 1'b0;
    end else begin
      state   <= state_n;
      rem     <= rem_n;
      mask_q  <= mask_n;
      tdest_q <= tdest_n;
      pass_q  <= pass_n;
      if (err_set) early_last_err <= 1'b1;
    end
  end

  // Skid buffer: ent0 is the head, new beats land in the first free slot after a pop.
  always_ff @(posedge clk) begin
    if (reset) begin
      ent0          <= '0;
      ent1          <= '0;
      cnt           <= '0;
      s_axis_tready <= 1'b0;
    end else begin
      if (pop) ent0 <= ent1;
      if (accept) begin
        if ((cnt - {1'b0, pop}) == 2'd0) ent0 <= nxt;
        else                              ent1 <= nxt;
      end
      cnt           <= cnt_n;
      s_axis_tready <= (cnt_n != 2'd2) && ((state_n == ACTIVE) || cfg_enable);
    end
  end

  // Completed-frame counter, wraps naturally at 32 bits.
  always_ff @(posedge clk) begin
    if (reset)                   frame_count <= '0;
    else if (pop && ent0.last)   frame_count <= frame_count + 32'd1;
  end

  assign m_axis_TVALID = (cnt != 2'd0);
  assign m_axis_TDATA  = ent0.data;
  assign m_axis_TKEEP  = ent0.keep;
  assign m_axis_TLAST  = ent0.last;
  assign m_axis_TDEST  = ent0.dest;
  assign m_axis_TUSER  = '0;
  assign m_axis_TID    = '0;
  assign busy          = (state == ACTIVE) || (cnt != 2'd0);

endmodule

// File: doc/rm_stream_framer.md
Name: rm_stream_framer

Overview:
- Sits directly upstream of the RM comm box S2MM stream input. Takes the raw 128-bit accelerator result stream and delivers framed AXI-Stream to the DMA.
- Frames are cut at a programmed byte length. TLAST is inserted and TKEEP is masked on the final partial beat.
- Early upstream TLAST is flagged, and completed frames are counted.
- A 2-entry skid buffer registers the output, so it sustains 1 beat/cycle with no combinational ready path.

Parameters:
- DATA_W, 128, stream data width in bits; must equal 8*KEEP_W
- KEEP_W, 16, bytes per beat; power of two
- LEN_W, 24, width of the frame byte-length config
- DEST_W, 8, width of TDEST/TID/TUSER

Ports:
- clk  in  1  single clock for all logic
- reset  in  1  synchronous, active-high reset
- cfg_enable  in  1  permits new frame starts; sampled only in IDLE
- cfg_frame_bytes  in  LEN_W  frame length in bytes; 0 = upstream-TLAST-delimited mode
- cfg_tdest  in  DEST_W  TDEST value for the frame; latched at frame start
- s_axis_tdata  in  DATA_W  upstream data
- s_axis_tkeep  in  KEEP_W  upstream byte enables
- s_axis_tlast  in  1  upstream end marker
- s_axis_tvalid  in  1  upstream valid
- s_axis_tready  out  1  upstream ready
- m_axis_TDATA  out  DATA_W  to S2MM TDATA
- m_axis_TKEEP  out  KEEP_W  to S2MM TKEEP
- m_axis_TLAST  out  1  to S2MM TLAST
- m_axis_TUSER  out  DEST_W  constant 0
- m_axis_TID  out  DEST_W  constant 0
- m_axis_TDEST  out  DEST_W  latched cfg_tdest
- m_axis_TVALID  out  1  output valid
- m_axis_TREADY  in  1  S2MM ready
- frame_count  out  32  frames completed on the output side
- early_last_err  out  1  sticky: upstream TLAST arrived before the programmed length
- busy  out  1  high in ACTIVE state or while the skid buffer holds data

Behaviour:
- Reset (synchronous, active-high, priority over all else):
  - state=IDLE; skid buffer emptied.
  - m_axis_TVALID=0, s_axis_tready=0 while reset is asserted.
  - frame_count=0, early_last_err=0, busy=0; all data outputs 0.
  - Reset mid-frame discards the partial frame; no TLAST is emitted for it.
- s_axis_tready is registered = skid buffer not full, additionally gated low in IDLE when cfg_enable=0.
- Accept: s_axis_tvalid&&s_axis_tready. Emit: m_axis_TVALID&&m_axis_TREADY.
- Output timing:
  - An accepted beat appears on m_axis no earlier than the next cycle (latency 1 when the buffer is empty).
  - Order is preserved; outputs hold stable while TVALID=1 and TREADY=0.
  - Simultaneous accept and emit keeps the occupancy unchanged.
- Length math, computed at frame start:
  - beats = ceil(cfg_frame_bytes/KEEP_W), held in a LEN_W-bit remaining counter.
  - last_mask = (cfg_frame_bytes mod KEEP_W)==0 ? all ones : (1<<(bytes mod KEEP_W))-1.
- IDLE: on accept with cfg_enable=1, latch beats, last_mask and cfg_tdest. The beat is the first of the frame.
  - If beats==1, or upstream tlast is set with cfg_frame_bytes!=0: beat is final, state stays IDLE.
  - Otherwise go to ACTIVE with rem=beats-1.
- ACTIVE: each accept decrements rem. When rem==1 the accepted beat is final, then return to IDLE.
- Final-beat output: TLAST=1, TKEEP = s_axis_tkeep & last_mask.
- Non-final beats: TLAST=0, TKEEP = s_axis_tkeep.
- Early upstream TLAST on a non-final beat:
  - Beat is emitted with TLAST=1 and unmasked TKEEP.
  - early_last_err set (sticky until reset); state returns to IDLE.
- Upstream TLAST missing at the final beat: TLAST is forced anyway, no error.
- cfg_frame_bytes==0:
  - Pure pass-through of tkeep and tlast; the frame ends on upstream tlast.
  - No error generation in this mode.
- Configuration changes: cfg changes while ACTIVE take effect only at the next frame start. Deasserting cfg_enable mid-frame does not stall the current frame.
- frame_count increments by 1 on each emitted beat with TLAST=1, and wraps 2^32-1 -> 0.

Test Plan:
- bytes=64, 4 upstream beats (tkeep=FFFF, tlast on beat 4), TREADY=1 -> 4 output beats, TLAST only on beat 4, TKEEP=FFFF throughout, frame_count=1, latency 1 cycle.
- bytes=40 -> 3 beats; beat 3 TKEEP=00FF with TLAST=1 even with upstream tlast=0; next frame restarts the count.
- bytes=64, upstream tlast on beat 2 -> beat 2 TLAST=1, early_last_err=1 and stays 1; the following frame is counted from 64 again; frame_count=2 after both frames.
- TREADY toggling 1,0,0,1 with continuous upstream valid -> no beat lost or duplicated, data held stable while stalled, s_axis_tready drops once 2 entries are buffered.
- cfg_enable=0 in IDLE -> s_axis_tready=0; raise cfg_enable -> frame starts; reset asserted mid-frame (beat 2 of 4) -> m_axis_TVALID=0 next cycle, frame_count=0.
- bytes=0, upstream 3 beats with tlast on beat 3 and tkeep=000F on beat 3 -> passed unchanged; frame_count preset near 2^32-1 wraps to 0.
